// File: rtl/plab4_net_router_input_queue.sv
// Input queue of the plab4 ring router: a circular buffer that presents its head
// message to the input control. Optional same-cycle bypass: PLAB4_NET_ROUTER_INPUT_QUEUE_BYPASS_EN.
module plab4_net_router_input_queue #(
  parameter int p_num_entries = 4,
  parameter int p_msg_nbits   = 44,
  parameter int p_num_routers = 8,
  localparam int c_dest_nbits = $clog2(p_num_routers),
  localparam int c_cnt_nbits  = $clog2(p_num_entries + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    domain,
  input  logic                    enq_val,
  output logic                    enq_rdy,
  input  logic [p_msg_nbits-1:0]  enq_msg,
  output logic                    deq_val,
  input  logic                    deq_rdy,
  output logic [p_msg_nbits-1:0]  deq_msg,
  output logic [c_dest_nbits-1:0] deq_dest,
  output logic [c_cnt_nbits-1:0]  num_free_entries
);

  localparam int c_ptr_nbits = $clog2(p_num_entries);

  // Pointer advance with an explicit wrap, so depths that are not a power of two work.
  function automatic logic [c_ptr_nbits-1:0] ptr_next(input logic [c_ptr_nbits-1:0] ptr);
    logic [c_ptr_nbits-1:0] nxt;
    if (ptr == c_ptr_nbits'(p_num_entries - 1)) begin
      nxt = {c_ptr_nbits{1'b0}};
    end else begin
      nxt = ptr + c_ptr_nbits'(1);
    end
    return nxt;
  endfunction

  logic [p_msg_nbits-1:0] storage_r [p_num_entries];
  logic [c_ptr_nbits-1:0] enq_ptr_r;
  logic [c_ptr_nbits-1:0] deq_ptr_r;
  logic [c_cnt_nbits-1:0] count_r;

  logic                   empty_s;
  logic                   full_s;
  logic                   enq_fire_s;
  logic                   deq_pop_s;
  logic                   byp_fire_s;
  logic                   wr_s;
  logic                   deq_val_s;
  logic [p_msg_nbits-1:0] deq_msg_s;

  // The domain label only qualifies the channel; the buffer itself ignores it.
  logic unused_domain_s;
  assign unused_domain_s = domain;

  assign empty_s    = (count_r == {c_cnt_nbits{1'b0}});
  assign full_s     = (count_r == c_cnt_nbits'(p_num_entries));
  assign enq_fire_s = enq_val && !full_s;
  assign deq_pop_s  = !empty_s && deq_rdy;
  assign wr_s       = enq_fire_s && !byp_fire_s;

  // Head presentation; with bypass an empty queue forwards the incoming message.
  always_comb begin
    deq_val_s  = !empty_s;
    deq_msg_s  = storage_r[deq_ptr_r];
    byp_fire_s = 1'b0;
`ifdef PLAB4_NET_ROUTER_INPUT_QUEUE_BYPASS_EN
    if (empty_s) begin
      deq_val_s  = enq_val;
      deq_msg_s  = enq_msg;
      byp_fire_s = enq_val && deq_rdy;
    end else begin
      deq_val_s  = 1'b1;
      deq_msg_s  = storage_r[deq_ptr_r];
      byp_fire_s = 1'b0;
    end
`endif
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr_r <= {c_ptr_nbits{1'b0}};
      deq_ptr_r <= {c_ptr_nbits{1'b0}};
      count_r   <= {c_cnt_nbits{1'b0}};
    end else begin
      if (wr_s) begin
        enq_ptr_r <= ptr_next(enq_ptr_r);
      end
      if (deq_pop_s) begin
        deq_ptr_r <= ptr_next(deq_ptr_r);
      end
      case ({wr_s, deq_pop_s})
        2'b10:   count_r <= count_r + c_cnt_nbits'(1);
        2'b01:   count_r <= count_r - c_cnt_nbits'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Message storage; a dequeued slot is scrubbed to zero so no stale payload lingers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        storage_r[i] <= {p_msg_nbits{1'b0}};
      end
    end else begin
      if (wr_s) begin
        storage_r[enq_ptr_r] <= enq_msg;
      end
      if (deq_pop_s) begin
        storage_r[deq_ptr_r] <= {p_msg_nbits{1'b0}};
      end
    end
  end

  assign enq_rdy          = !full_s;
  assign deq_val          = deq_val_s;
  assign deq_msg          = deq_msg_s;
  assign deq_dest         = deq_msg_s[p_msg_nbits-1 -: c_dest_nbits];
  assign num_free_entries = c_cnt_nbits'(p_num_entries) - count_r;

endmodule

// File: tb/tb_plab4_net_router_input_queue.sv
// Bench for plab4_net_router_input_queue: depth-4 and depth-3 instances share the
// stimulus and are each compared against a queue model every cycle.
module tb_plab4_net_router_input_queue;

  typedef logic [43:0] msg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic domain = 1'b0;
  logic enq_val = 1'b0;
  msg_t enq_msg = '0;
  logic deq_rdy = 1'b0;

  logic enq_rdy4, deq_val4, enq_rdy3, deq_val3;
  msg_t deq_msg4, deq_msg3;
  logic [2:0] deq_dest4, deq_dest3;
  logic [2:0] free4;
  logic [1:0] free3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  plab4_net_router_input_queue #(.p_num_entries(4), .p_msg_nbits(44), .p_num_routers(8)) dut4 (
    .clk(clk), .reset(reset), .domain(domain),
    .enq_val(enq_val), .enq_rdy(enq_rdy4), .enq_msg(enq_msg),
    .deq_val(deq_val4), .deq_rdy(deq_rdy), .deq_msg(deq_msg4),
    .deq_dest(deq_dest4), .num_free_entries(free4)
  );

  plab4_net_router_input_queue #(.p_num_entries(3), .p_msg_nbits(44), .p_num_routers(8)) dut3 (
    .clk(clk), .reset(reset), .domain(domain),
    .enq_val(enq_val), .enq_rdy(enq_rdy3), .enq_msg(enq_msg),
    .deq_val(deq_val3), .deq_rdy(deq_rdy), .deq_msg(deq_msg3),
    .deq_dest(deq_dest3), .num_free_entries(free3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: one FIFO per instance holding the accepted messages in order.
  msg_t mq [2][$];
  int depth [2] = '{4, 3};
  logic domain_q = 1'b0;
  bit m_empty, m_full, m_dfire, m_efire, m_byp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      assert (domain == domain_q || (mq[0].size() == 0 && mq[1].size() == 0))
        else $error("domain changed while queue holds messages");
      for (int k = 0; k < 2; k++) begin
        m_empty = (mq[k].size() == 0);
        m_full  = (mq[k].size() == depth[k]);
        m_byp   = 1'b0;
`ifdef PLAB4_NET_ROUTER_INPUT_QUEUE_BYPASS_EN
        m_byp   = m_empty && enq_val && deq_rdy;
`endif
        m_dfire = !m_empty && deq_rdy;
        m_efire = enq_val && !m_full && !m_byp;
        if (m_dfire) void'(mq[k].pop_front());
        if (m_efire) mq[k].push_back(enq_msg);
      end
    end
    domain_q <= domain;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic exp_val;
    msg_t exp_msg;
    for (int k = 0; k < 2; k++) begin
      exp_val = (mq[k].size() != 0);
      exp_msg = exp_val ? mq[k][0] : '0;
`ifdef PLAB4_NET_ROUTER_INPUT_QUEUE_BYPASS_EN
      if (mq[k].size() == 0) begin
        exp_val = enq_val;
        exp_msg = enq_msg;
      end
`endif
      if (k == 0) begin
        check("m4_enq_rdy", 64'(enq_rdy4), 64'(mq[0].size() < 4));
        check("m4_deq_val", 64'(deq_val4), 64'(exp_val));
        check("m4_deq_msg", 64'(deq_msg4), 64'(exp_msg));
        check("m4_deq_dest", 64'(deq_dest4), 64'(exp_msg[43:41]));
        check("m4_free", 64'(free4), 64'(4 - mq[0].size()));
      end else begin
        check("m3_enq_rdy", 64'(enq_rdy3), 64'(mq[1].size() < 3));
        check("m3_deq_val", 64'(deq_val3), 64'(exp_val));
        check("m3_deq_msg", 64'(deq_msg3), 64'(exp_msg));
        check("m3_deq_dest", 64'(deq_dest3), 64'(exp_msg[43:41]));
        check("m3_free", 64'(free3), 64'(3 - mq[1].size()));
      end
    end
  end

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic cyc(input logic ev, input msg_t msg, input logic dr);
    @(posedge clk);
    #1;
    enq_val = ev;
    enq_msg = msg;
    deq_rdy = dr;
    @(negedge clk);
  endtask

  int p_enq [6] = '{90, 50, 10, 90, 70, 30};
  int p_deq [6] = '{10, 50, 90, 90, 30, 70};

  initial begin
    #12 reset = 1'b0;

    cyc(1'b0, '0, 1'b0);
    check("rst_enq_rdy", 64'(enq_rdy4), 64'd1);
    check("rst_deq_val", 64'(deq_val4), 64'd0);
    check("rst_deq_msg", 64'(deq_msg4), 64'd0);
    check("rst_free4", 64'(free4), 64'd4);
    check("rst_free3", 64'(free3), 64'd3);

    // Fill with A..D, then try an enqueue against a full queue while dequeuing.
    cyc(1'b1, 44'hA, 1'b0);
    cyc(1'b1, 44'hB, 1'b0);
    cyc(1'b1, 44'hC, 1'b0);
    cyc(1'b1, 44'hD, 1'b0);
    cyc(1'b1, 44'hE, 1'b1);
    check("full_enq_rdy", 64'(enq_rdy4), 64'd0);
    check("full_free", 64'(free4), 64'd0);
    check("full_head", 64'(deq_msg4), 64'hA);
    cyc(1'b1, 44'hE, 1'b0);
    check("full_deq_free", 64'(free4), 64'd1);
    check("full_deq_rdy", 64'(enq_rdy4), 64'd1);
    check("full_deq_head", 64'(deq_msg4), 64'hB);
    cyc(1'b0, '0, 1'b1);
    check("refill_free", 64'(free4), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
    check("drain_val", 64'(deq_val4), 64'd0);
    check("drain_msg", 64'(deq_msg4), 64'd0);
    check("drain_free", 64'(free4), 64'd4);

    // Back-to-back simultaneous enqueue/dequeue with two entries held.
    cyc(1'b1, 44'h100, 1'b0);
    cyc(1'b1, 44'h101, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 44'h200 + 44'(i), 1'b1);
    cyc(1'b0, '0, 1'b0);
    check("b2b_free4", 64'(free4), 64'd2);
    check("b2b_free3", 64'(free3), 64'd1);
    check("b2b_head4", 64'(deq_msg4), 64'h212);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    check("b2b_empty", 64'(deq_val4), 64'd0);

    // Destination field, then asynchronous reset with two entries held.
    cyc(1'b1, {3'd5, 41'h123}, 1'b0);
    cyc(1'b1, 44'h0AB, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("dest5", 64'(deq_dest4), 64'd5);
    check("dest_free", 64'(free4), 64'd2);
    #1 reset = 1'b1;
    #1;
    check("arst_val4", 64'(deq_val4), 64'd0);
    check("arst_msg4", 64'(deq_msg4), 64'd0);
    check("arst_dest4", 64'(deq_dest4), 64'd0);
    check("arst_free4", 64'(free4), 64'd4);
    check("arst_val3", 64'(deq_val3), 64'd0);
    domain = 1'b1;
    #1 reset = 1'b0;
    cyc(1'b1, 44'h55, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("post_rst_head", 64'(deq_msg4), 64'h55);
    cyc(1'b0, '0, 1'b0);

    // Empty-queue enqueue with deq_rdy high: bypass versus one-cycle latency.
    cyc(1'b1, 44'h7, 1'b1);
`ifdef PLAB4_NET_ROUTER_INPUT_QUEUE_BYPASS_EN
    check("byp_val", 64'(deq_val4), 64'd1);
    check("byp_msg", 64'(deq_msg4), 64'h7);
    cyc(1'b0, '0, 1'b0);
    check("byp_next_val", 64'(deq_val4), 64'd0);
    check("byp_next_free", 64'(free4), 64'd4);
`else
    check("lat_val0", 64'(deq_val4), 64'd0);
    check("lat_msg0", 64'(deq_msg4), 64'd0);
    cyc(1'b0, '0, 1'b0);
    check("lat_val1", 64'(deq_val4), 64'd1);
    check("lat_msg1", 64'(deq_msg4), 64'h7);
    check("lat_free1", 64'(free4), 64'd3);
`endif
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Randomized traffic in phases of differing enqueue/dequeue pressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        cyc(($urandom_range(99) < p_enq[ph]) ? 1'b1 : 1'b0,
            {12'($urandom), 32'($urandom)},
            ($urandom_range(99) < p_deq[ph]) ? 1'b1 : 1'b0);
      end
    end

    cyc(1'b0, '0, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
